// File: rtl/decoder_2x4_strobe.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake, a one-entry pending
// buffer, and a per-strobe HOLD-cycle high phase followed by a GAP-cycle low phase.
module decoder_2x4_strobe #(
  parameter int unsigned HOLD = 4,  // 1..255
  parameter int unsigned GAP  = 0   // 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_code,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic [7:0] strobe_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_code_q, pend_code_d;
  logic [3:0] y_d;
  logic [7:0] strobe_cnt_d;
  logic       accept;
  logic       period_end;

  // Inverse of the 4x2 encoder: code 0 lights the MSB, code 3 the LSB.
  function automatic logic [3:0] decode(input logic [1:0] code);
    return 4'b1000 >> code;
  endfunction

  assign in_ready   = !pend_valid_q;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != ST_IDLE) || pend_valid_q;
  assign period_end = (cnt_q == 8'd0) &&
                      ((state_q == ST_GAP) || (state_q == ST_HOLD && GAP == 0));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    y_d          = y;
    strobe_cnt_d = strobe_cnt;

    if (abort) begin
      state_d      = ST_IDLE;
      cnt_d        = 8'd0;
      pend_valid_d = 1'b0;
      y_d          = 4'b0000;
    end else if (period_end) begin
      // Pending entry has priority; a same-edge accept only happens when pending is empty.
      if (pend_valid_q || accept) begin
        state_d      = ST_HOLD;
        cnt_d        = HOLD_LOAD;
        y_d          = decode(pend_valid_q ? pend_code_q : in_code);
        pend_valid_d = 1'b0;
        strobe_cnt_d = strobe_cnt + 8'd1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        y_d     = 4'b0000;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d      = ST_HOLD;
            cnt_d        = HOLD_LOAD;
            y_d          = decode(in_code);
            strobe_cnt_d = strobe_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
            y_d     = 4'b0000;
          end
        end
        ST_GAP: begin
          cnt_d = cnt_q - 8'd1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          y_d     = 4'b0000;
        end
      endcase

      if (accept && state_q != ST_IDLE) begin
        pend_valid_d = 1'b1;
        pend_code_d  = in_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 2'd0;
      y            <= 4'b0000;
      y_valid      <= 1'b0;
      strobe_cnt   <= 8'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      y            <= y_d;
      y_valid      <= |y_d;
      strobe_cnt   <= strobe_cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_2x4_strobe.sv
// Self-checking bench for decoder_2x4_strobe: two instances (HOLD=3/GAP=0 and
// HOLD=2/GAP=2) share stimulus and are compared against a timeline model.
module tb_decoder_2x4_strobe;

  localparam int HOLD_A = 3;
  localparam int GAP_A  = 0;
  localparam int HOLD_B = 2;
  localparam int GAP_B  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'd0;

  logic       in_ready_a, y_valid_a, busy_a;
  logic [3:0] y_a;
  logic [7:0] cnt_a;
  logic       in_ready_b, y_valid_b, busy_b;
  logic [3:0] y_b;
  logic [7:0] cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_2x4_strobe #(.HOLD(HOLD_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_code(in_code), .y(y_a), .y_valid(y_valid_a), .busy(busy_a), .strobe_cnt(cnt_a)
  );

  decoder_2x4_strobe #(.HOLD(HOLD_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_code(in_code), .y(y_b), .y_valid(y_valid_b), .busy(busy_b), .strobe_cnt(cnt_b)
  );

  wire logic [14:0] out_a = {y_a, y_valid_a, in_ready_a, busy_a, cnt_a};
  wire logic [14:0] out_b = {y_b, y_valid_b, in_ready_b, busy_b, cnt_b};

  // Timeline model: each strobe occupies HOLD+GAP cycles measured from its launch.
  int m_hold[2] = '{HOLD_A, HOLD_B};
  int m_gap[2]  = '{GAP_A, GAP_B};
  int m_phase[2];     // cycles since launch, -1 when idle
  int m_cur[2];
  bit m_pv[2];
  int m_pc[2];
  int m_cnt[2];
  int m_launches[2];

  function automatic logic [3:0] m_y(int i);
    if (m_phase[i] >= 0 && m_phase[i] < m_hold[i]) return 4'(1 << (3 - m_cur[i]));
    return 4'b0000;
  endfunction

  function automatic logic [14:0] m_out(int i);
    logic [3:0] yy;
    yy = m_y(i);
    return {yy, |yy, ~m_pv[i], (m_phase[i] >= 0) || m_pv[i], 8'(m_cnt[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = -1;
      m_cur[i] = 0;
      m_pv[i] = 1'b0;
      m_pc[i] = 0;
      m_cnt[i] = 0;
      m_launches[i] = 0;
    end
  endtask

  task automatic m_start(int i, int code);
    m_cur[i] = code;
    m_phase[i] = 0;
    m_cnt[i] = (m_cnt[i] + 1) % 256;
    m_launches[i]++;
  endtask

  task automatic model_edge();
    bit acc;
    for (int i = 0; i < 2; i++) begin
      acc = in_valid && !m_pv[i];
      if (abort) begin
        m_phase[i] = -1;
        m_pv[i] = 1'b0;
      end else if (m_phase[i] < 0) begin
        if (acc) m_start(i, int'(in_code));
      end else if (m_phase[i] == m_hold[i] + m_gap[i] - 1) begin
        if (m_pv[i]) begin
          m_start(i, m_pc[i]);
          m_pv[i] = 1'b0;
        end else if (acc) begin
          m_start(i, int'(in_code));
        end else begin
          m_phase[i] = -1;
        end
      end else begin
        m_phase[i]++;
        if (acc) begin
          m_pv[i] = 1'b1;
          m_pc[i] = int'(in_code);
        end
      end
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so they are stable here.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    model_reset();
    #12 rst = 1'b0;
    #1;
    checks++;
    if (out_a !== 15'b0000_0_1_0_00000000) begin
      failures++;
      $display("FAIL reset_a: got %h expected %h", out_a, 15'b0000_0_1_0_00000000);
    end
    checks++;
    if (out_b !== 15'b0000_0_1_0_00000000) begin
      failures++;
      $display("FAIL reset_b: got %h expected %h", out_b, 15'b0000_0_1_0_00000000);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_y[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    in_valid = 1'b1;
    in_code = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b0;
      checks++;
      if (y_a !== exp_y[i]) begin
        failures++;
        $display("FAIL single_y[%0d]: got %b expected %b", i, y_a, exp_y[i]);
      end
    end
    checks++;
    if (busy_a !== 1'b0 || cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL single_end: busy=%b cnt=%0d expected busy=0 cnt=1", busy_a, cnt_a);
    end
    idle(8);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_y[7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    in_valid = 1'b1;
    in_code = 2'd0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) in_code = 2'd3;
      if (i == 1) begin
        in_valid = 1'b0;
        checks++;
        if (in_ready_a !== 1'b0) begin
          failures++;
          $display("FAIL b2b_in_ready: got %b expected 0", in_ready_a);
        end
      end
      checks++;
      if (y_a !== exp_y[i]) begin
        failures++;
        $display("FAIL b2b_y[%0d]: got %b expected %b", i, y_a, exp_y[i]);
      end
    end
    idle(8);
  endtask

  task automatic test_gap();
    logic [3:0] exp_y[7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    in_valid = 1'b1;
    in_code = 2'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) in_code = 2'd3;
      if (i == 1) in_valid = 1'b0;
      checks++;
      if (y_b !== exp_y[i] || y_valid_b !== |exp_y[i]) begin
        failures++;
        $display("FAIL gap_y[%0d]: got y=%b v=%b expected y=%b v=%b",
                 i, y_b, y_valid_b, exp_y[i], |exp_y[i]);
      end
    end
    idle(8);
  endtask

  task automatic test_same_edge_launch();
    logic [3:0] exp_y[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      in_valid = (i == 0 || i == 3);
      in_code = (i == 0) ? 2'd1 : 2'd2;
      tick();
      in_valid = 1'b0;
      if (i == 3) begin
        checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b1) begin
          failures++;
          $display("FAIL same_edge_status: in_ready=%b busy=%b expected 1 1", in_ready_a, busy_a);
        end
      end
      checks++;
      if (y_a !== exp_y[i]) begin
        failures++;
        $display("FAIL same_edge_y[%0d]: got %b expected %b", i, y_a, exp_y[i]);
      end
    end
    idle(8);
  endtask

  task automatic test_abort();
    int saved;
    in_valid = 1'b1;
    in_code = 2'd0;
    tick();
    in_code = 2'd1;
    tick();
    saved = m_cnt[0];
    in_code = 2'd2;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (y_a !== 4'b0000 || in_ready_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 8'(saved)) begin
      failures++;
      $display("FAIL abort_a: y=%b rdy=%b busy=%b cnt=%0d expected 0000 1 0 %0d",
               y_a, in_ready_a, busy_a, cnt_a, saved);
    end
    checks++;
    if (out_b !== m_out(1)) begin
      failures++;
      $display("FAIL abort_b: got %h expected %h", out_b, m_out(1));
    end
    in_valid = 1'b1;
    in_code = 2'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y_a !== 4'b0001) begin
      failures++;
      $display("FAIL abort_resume: got %b expected 0001", y_a);
    end
    idle(8);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code = 2'($urandom_range(0, 3));
      abort = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (out_a !== m_out(0)) begin
        failures++;
        $display("FAIL rand_a cycle %0d: got %h expected %h", c, out_a, m_out(0));
      end
      checks++;
      if (out_b !== m_out(1)) begin
        failures++;
        $display("FAIL rand_b cycle %0d: got %h expected %h", c, out_b, m_out(1));
      end
    end
    idle(10);
  endtask

  task automatic test_async_reset_wrap();
    int guard;
    in_valid = 1'b1;
    in_code = 2'd2;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y_a !== 4'b0000 || y_valid_a !== 1'b0 || y_b !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: y_a=%b v_a=%b y_b=%b expected 0000 0 0000", y_a, y_valid_a, y_b);
    end
    model_reset();
    #2 rst = 1'b0;
    in_valid = 1'b1;
    guard = 0;
    while (m_launches[0] < 256 && guard < 2000) begin
      in_code = 2'($urandom_range(0, 3));
      tick();
      guard++;
      checks++;
      if (out_a !== m_out(0)) begin
        failures++;
        $display("FAIL wrap_a cycle %0d: got %h expected %h", guard, out_a, m_out(0));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (m_launches[0] < 256 || cnt_a !== 8'd0) begin
      failures++;
      $display("FAIL wrap_cnt: launches=%0d cnt=%0d expected 256 launches and cnt 0",
               m_launches[0], cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_same_edge_launch();
    test_abort();
    test_random();
    test_async_reset_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decoder_2x4_strobe.md
Name: decoder_2x4_strobe

Overview:
- Registered 2-to-4 one-hot decoder with a valid/ready input handshake.
- Each accepted 2-bit code drives a one-hot strobe that is held for HOLD cycles, followed by GAP idle cycles.
- A one-entry pending buffer lets a producer queue the next code while the current strobe is active.
- Sits on the return path of the 4-to-2 encode chain and drives one-hot select/enable lines from compact codes.

Parameters:
HOLD, 4, cycles each strobe is held high; legal range 1..255.
GAP, 0, forced all-zero cycles after each strobe; legal range 0..255.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
abort  input  1  synchronous flush; priority above all other inputs except rst.
in_valid  input  1  in_code is valid.
in_ready  output  1  block can accept a code this cycle.
in_code  input  2  code to decode.
y  output  4  one-hot strobe, registered.
y_valid  output  1  high exactly while y is non-zero.
busy  output  1  state is not IDLE, or pending entry is full.
strobe_cnt  output  8  count of strobes launched; wraps 255->0.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, y=0000, y_valid=0, pending empty, hold/gap counter=0, strobe_cnt=0.
  - in_ready=1 once rst deasserts.
- Accept rule: a code is accepted on a clk edge where in_valid=1 and in_ready=1.
  - in_ready = !pend_valid. It is combinational from state and pending registers only, never from in_valid.
- Decode mapping (fixed, inverse of the team's 4x2 encoder):
  - code 0 -> y=1000, code 1 -> 0100, code 2 -> 0010, code 3 -> 0001.
  - Equivalently, y[3-code]=1.
- States: IDLE, HOLD, GAP.
- IDLE:
  - Accept -> next cycle y=decode(in_code), y_valid=1, state=HOLD, cnt=HOLD-1, strobe_cnt+1.
  - Latency is 1 cycle from the accept edge to y.
- HOLD:
  - y is held constant.
  - cnt!=0 -> cnt-1.
  - cnt==0 and GAP>0 -> state=GAP, cnt=GAP-1, y=0000.
  - cnt==0 and GAP==0 -> launch.
- GAP:
  - y=0000.
  - cnt!=0 -> cnt-1.
  - cnt==0 -> launch.
- Launch (end of HOLD with GAP==0, or end of GAP):
  - Source is the pending entry if valid; otherwise in_code if accepted on this same edge.
  - With a source: y=decode(source), state=HOLD, cnt=HOLD-1, pending cleared, strobe_cnt+1. Strobes are back-to-back with no zero cycle when GAP=0.
  - Without a source: state=IDLE, y=0000.
- Accept in HOLD/GAP that is not consumed by a launch on the same edge -> stored in pending.
- Pending full -> in_ready=0. A producer holding in_valid high waits; its data must stay stable.
- abort=1 at an edge:
  - state=IDLE, y=0000, pending cleared, cnt=0.
  - strobe_cnt unchanged.
  - Any accept on that edge is discarded.
- rst mid-strobe: y drops to 0000 immediately (asynchronous); pending is lost.
- y_valid = |y, registered consistently with y.
- No X propagation: in_code is ignored unless the accept condition holds.

Test Plan:
1. Reset, then HOLD=3, GAP=0: accept code 2 at edge t -> y=0010 at t+1..t+3; y=0000 and state IDLE at t+4; strobe_cnt=1.
2. HOLD=3, GAP=0: accept code 0 at t, then code 3 at t+1 -> in_ready=0 at t+2; y=1000 for t+1..t+3, then y=0001 for t+4..t+6; no zero cycle between them.
3. HOLD=2, GAP=2: accept code 1 then code 3 -> y=0100 for 2 cycles, 0000 for 2 cycles, 0001 for 2 cycles; y_valid tracks |y exactly.
4. HOLD=3, GAP=0, pending empty: accept on the last HOLD edge (same-edge launch) -> new strobe starts on the next cycle with no IDLE cycle; pending stays empty.
5. Mid-HOLD with pending full: abort=1 for 1 cycle -> next cycle y=0000, in_ready=1, busy=0, strobe_cnt unchanged; a new code then decodes normally.
6. Mid-strobe: pulse rst between clock edges -> y=0000 without waiting for clk; after release, 256 back-to-back strobes -> strobe_cnt wraps to 0.
